brick_manager: RTL

- Owns the six breakable bricks of the playfield.
- Drives fixed brick coordinates and the live `bricks_exist` mask into the ball engine.
- Watches the ball position and retires a brick once the ball has struck it and moved clear. Retiring is deferred so the ball engine still sees the brick during its collide/bounce pass.
- Keeps the score, pulses a hit strobe per retirement and flags level clear for the top-level game controller.

---
 rtl/brick_manager.sv | 89 ++++++++
 1 files changed

// File: rtl/brick_manager.sv
// brick_manager: six breakable bricks with deferred retirement, score and level-clear tracking
module brick_manager #(
  parameter int COL0_X    = 163,
  parameter int COL_PITCH = 110,
  parameter int ROW0_Y    = 60,
  parameter int ROW1_Y    = 100,
  parameter int BRICK_W   = 57,
  parameter int BRICK_H   = 19,
  parameter int BALL_SZ   = 20,
  parameter int POINTS    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [8:0] ball_x,
  input  logic [8:0] ball_y,
  output logic [8:0] brick1_x,
  output logic [8:0] brick2_x,
  output logic [8:0] brick3_x,
  output logic [8:0] brick4_x,
  output logic [8:0] brick5_x,
  output logic [8:0] brick6_x,
  output logic [8:0] brick1_y,
  output logic [8:0] brick2_y,
  output logic [8:0] brick3_y,
  output logic [8:0] brick4_y,
  output logic [8:0] brick5_y,
  output logic [8:0] brick6_y,
  output logic [5:0] bricks_exist,
  output logic [7:0] score,
  output logic       brick_hit,
  output logic       all_cleared
);
  typedef enum logic [1:0] {PRESENT, HIT, GONE} state_t;
  state_t      st   [6];
  state_t      st_n [6];
  logic [9:0]  bx   [6];
  logic [9:0]  by   [6];
  logic [5:0]  ov;
  logic [5:0]  retire;
  logic [5:0]  exist_n;
  logic [11:0] sum;
  logic [7:0]  score_n;
  for (genvar b = 0; b < 6; b++) begin : g_brick
    assign bx[b] = 10'(COL0_X + (b % 3) * COL_PITCH);
    assign by[b] = 10'(b < 3 ? ROW0_Y : ROW1_Y);
    assign ov[b] = ({1'b0, ball_x} <= bx[b] + 10'(BRICK_W)) && ({1'b0, ball_x} + 10'(BALL_SZ) >= bx[b]) &&
                   ({1'b0, ball_y} <= by[b] + 10'(BRICK_H)) && ({1'b0, ball_y} + 10'(BALL_SZ) >= by[b]);
    assign bricks_exist[b] = st[b] != GONE;
  end
  assign brick1_x = bx[0][8:0];
  assign brick2_x = bx[1][8:0];
  assign brick3_x = bx[2][8:0];
  assign brick4_x = bx[3][8:0];
  assign brick5_x = bx[4][8:0];
  assign brick6_x = bx[5][8:0];
  assign brick1_y = by[0][8:0];
  assign brick2_y = by[1][8:0];
  assign brick3_y = by[2][8:0];
  assign brick4_y = by[3][8:0];
  assign brick5_y = by[4][8:0];
  assign brick6_y = by[5][8:0];
  // next brick states; a brick retires only once the ball has left it, restart overrides everything
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      st_n[i]    = restart ? PRESENT :
                   (st[i] == PRESENT && ov[i]) ? HIT :
                   (st[i] == HIT && !ov[i]) ? GONE : st[i];
      retire[i]  = !restart && st[i] == HIT && !ov[i];
      exist_n[i] = st_n[i] != GONE;
    end
    sum     = 12'(score) + 12'($countones(retire) * POINTS);
    score_n = sum > 12'd255 ? 8'd255 : sum[7:0];
  end
  // brick states, saturating score, retirement strobe and level-clear flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) st[i] <= PRESENT;
      score       <= '0;
      brick_hit   <= 1'b0;
      all_cleared <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) st[i] <= st_n[i];
      score       <= restart ? '0 : score_n;
      brick_hit   <= |retire;
      all_cleared <= ~|exist_n;
    end
  end
endmodule
